line_mem_ctrl: RTL and testbench

//  Downstream stage of the line cache: services whole-line fill and write-back requests on a word-serial external bus.
//  - Fill: reads LINE_WORDS words from external memory and returns them as one line.
//  - Write-back: writes the supplied line out word by word.
//  - Signals completion to the cache with a one-cycle done pulse.

---
 rtl/line_mem_ctrl.sv | 100 ++++++++++
 tb/tb_line_mem_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/line_mem_ctrl.sv
// rtl/line_mem_ctrl.sv - whole-line fill / write-back engine on a word-serial external bus
module line_mem_ctrl #(
  parameter int LINE_WORDS = 16,
  parameter int ADDR_W     = 24,
  parameter int WORD_W     = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_r_en,
  input  logic                         mem_w_en,
  input  logic [ADDR_W-1:0]            mem_addr,
  input  logic [LINE_WORDS*WORD_W-1:0] line_store,
  output logic [LINE_WORDS*WORD_W-1:0] line_read,
  output logic                         mem_ready,
  output logic                         mem_done,
  output logic                         ext_req,
  output logic                         ext_we,
  output logic [ADDR_W-1:0]            ext_addr,
  output logic [WORD_W-1:0]            ext_wdata,
  input  logic [WORD_W-1:0]            ext_rdata,
  input  logic                         ext_ack
);

  localparam int CNT_W = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_WORDS - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WR_BURST = 2'd1;
  localparam logic [1:0] RD_BURST = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  logic [1:0]               state;
  logic [CNT_W-1:0]         cnt;
  logic [ADDR_W-CNT_W-1:0]  base_hi;
  logic                     pend_rd;
  logic [WORD_W-1:0]        wbuf [LINE_WORDS];
  logic                     last_word;
  logic                     unused_addr_lsbs;

  // Word offset inside the line is dropped; the counter supplies it instead,
  // so the burst address can never carry into the neighbouring line.
  assign unused_addr_lsbs = ^mem_addr[CNT_W-1:0];

  assign last_word = (cnt == LAST_CNT);
  assign mem_ready = (state == IDLE);
  assign mem_done  = (state == DONE);
  assign ext_req   = (state == WR_BURST) || (state == RD_BURST);
  assign ext_we    = (state == WR_BURST);
  assign ext_addr  = {base_hi, cnt};
  assign ext_wdata = wbuf[cnt];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      base_hi   <= '0;
      pend_rd   <= 1'b0;
      line_read <= '0;
      for (int i = 0; i < LINE_WORDS; i++) begin
        wbuf[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (mem_r_en || mem_w_en) begin
            base_hi <= mem_addr[ADDR_W-1:CNT_W];
            cnt     <= '0;
            pend_rd <= mem_r_en;
            for (int i = 0; i < LINE_WORDS; i++) begin
              wbuf[i] <= line_store[i*WORD_W +: WORD_W];
            end
            // A combined request writes back first, then fills the same line.
            state <= mem_w_en ? WR_BURST : RD_BURST;
          end
        end
        WR_BURST: begin
          if (ext_ack) begin
            cnt <= cnt + 1'b1;
            if (last_word) begin
              state <= pend_rd ? RD_BURST : DONE;
            end
          end
        end
        RD_BURST: begin
          if (ext_ack) begin
            line_read[int'(cnt)*WORD_W +: WORD_W] <= ext_rdata;
            cnt <= cnt + 1'b1;
            if (last_word) begin
              state <= DONE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_mem_ctrl.sv
// tb/tb_line_mem_ctrl.sv - directed self-checking bench for line_mem_ctrl
module tb_line_mem_ctrl;

  localparam int LW = 16;
  localparam int AW = 24;
  localparam int WW = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           mem_r_en;
  logic           mem_w_en;
  logic [AW-1:0]  mem_addr;
  logic [LW*WW-1:0] line_store;
  logic [LW*WW-1:0] line_read;
  logic           mem_ready;
  logic           mem_done;
  logic           ext_req;
  logic           ext_we;
  logic [AW-1:0]  ext_addr;
  logic [WW-1:0]  ext_wdata;
  logic [WW-1:0]  ext_rdata;
  logic           ext_ack;

  int tests = 0;
  int fails = 0;

  int            xfers;
  logic [AW-1:0] xa [64];
  logic          xw [64];
  logic [WW-1:0] xd [64];
  int            done_cnt;
  int            done_cyc;
  int            req_falls;
  int            ready_bad;
  logic          timed_out;

  line_mem_ctrl dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .mem_addr(mem_addr), .line_store(line_store), .line_read(line_read),
    .mem_ready(mem_ready), .mem_done(mem_done), .ext_req(ext_req),
    .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_ack(ext_ack)
  );

  always #5 clk = ~clk;

  // External memory returns its own word address as read data.
  assign ext_rdata = {8'h00, ext_addr};

  // Issues one request and runs the bus until the block is back in IDLE.
  task automatic run_op(input logic r, input logic w, input logic [AW-1:0] addr,
                        input int period, input logic inj);
    int n;
    int rc;
    logic prev_req;
    logic ack;
    xfers = 0; done_cnt = 0; done_cyc = 0; req_falls = 0; ready_bad = 0;
    timed_out = 1'b0;
    @(negedge clk);
    mem_r_en = r; mem_w_en = w; mem_addr = addr;
    @(negedge clk);
    mem_w_en = 1'b0; mem_addr = ~addr;
    n = 2; rc = 0; prev_req = 1'b0;
    forever begin
      mem_r_en = 1'b0;
      ext_ack  = 1'b0;
      if (prev_req && !ext_req) req_falls++;
      prev_req = ext_req;
      if (mem_done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = n;
      end
      if (done_cnt != 0 && mem_ready) break;
      if (mem_ready) ready_bad++;
      if (ext_req) begin
        ack = ((rc % period) == period - 1);
        rc++;
        if (ack) begin
          if (xfers < 64) begin
            xa[xfers] = ext_addr; xw[xfers] = ext_we; xd[xfers] = ext_wdata;
          end
          xfers++;
          ext_ack = 1'b1;
        end
        if (inj && !ext_we && rc == 5) mem_r_en = 1'b1;
      end
      if (inj && mem_done) mem_r_en = 1'b1;
      if (n > 300) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
    mem_r_en = 1'b0;
    ext_ack  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    tests++; if (mem_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", mem_ready); end
    tests++; if (mem_done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", mem_done); end
    tests++; if (ext_req !== 1'b0 || ext_we !== 1'b0) begin fails++; $display("FAIL reset_req_we got %b%b want 00", ext_req, ext_we); end
    tests++; if (ext_addr !== 24'h0 || ext_wdata !== 32'h0) begin fails++; $display("FAIL reset_addr_wdata got %h/%h want 0/0", ext_addr, ext_wdata); end
    tests++; if (line_read !== '0) begin fails++; $display("FAIL reset_line_read got nonzero want 0"); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill();
    logic [WW-1:0] expw;
    run_op(1'b1, 1'b0, 24'h000123, 1, 1'b0);
    tests++; if (timed_out !== 1'b0) begin fails++; $display("FAIL fill_timeout got %b want 0", timed_out); end
    tests++; if (xfers != 16) begin fails++; $display("FAIL fill_xfers got %0d want 16", xfers); end
    for (int i = 0; i < 16; i++) begin
      expw = 32'h00000120 + i;
      tests++; if (xa[i] !== expw[AW-1:0] || xw[i] !== 1'b0) begin fails++; $display("FAIL fill_addr[%0d] got %h we=%b want %h we=0", i, xa[i], xw[i], expw[AW-1:0]); end
      tests++; if (line_read[i*WW +: WW] !== expw) begin fails++; $display("FAIL fill_line[%0d] got %h want %h", i, line_read[i*WW +: WW], expw); end
    end
    tests++; if (done_cyc != 18) begin fails++; $display("FAIL fill_latency got %0d want 18", done_cyc); end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL fill_done_count got %0d want 1", done_cnt); end
    tests++; if (ready_bad != 0) begin fails++; $display("FAIL fill_ready_busy got %0d want 0", ready_bad); end
  endtask

  task automatic test_spurious_ack();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ext_ack = 1'b1;
      @(negedge clk);
      ext_ack = 1'b0;
      tests++; if (mem_ready !== 1'b1 || ext_req !== 1'b0) begin fails++; $display("FAIL spur_state got ready=%b req=%b want 1/0", mem_ready, ext_req); end
    end
    tests++; if (line_read[0 +: WW] !== 32'h00000120 || line_read[15*WW +: WW] !== 32'h0000012F) begin
      fails++; $display("FAIL spur_line got %h/%h want 00000120/0000012f", line_read[0 +: WW], line_read[15*WW +: WW]);
    end
  endtask

  task automatic test_writeback();
    for (int i = 0; i < LW; i++) line_store[i*WW +: WW] = 32'hA5A50000 + i;
    run_op(1'b0, 1'b1, 24'h0005A7, 3, 1'b0);
    line_store = '0;
    tests++; if (timed_out !== 1'b0) begin fails++; $display("FAIL wb_timeout got %b want 0", timed_out); end
    tests++; if (xfers != 16) begin fails++; $display("FAIL wb_xfers got %0d want 16", xfers); end
    for (int i = 0; i < 16; i++) begin
      tests++; if (xa[i] !== 24'h0005A0 + 24'(i) || xw[i] !== 1'b1 || xd[i] !== 32'hA5A50000 + i) begin
        fails++; $display("FAIL wb_word[%0d] got a=%h we=%b d=%h want a=%h we=1 d=%h", i, xa[i], xw[i], xd[i], 24'h0005A0 + 24'(i), 32'hA5A50000 + i);
      end
    end
    tests++; if (req_falls != 1) begin fails++; $display("FAIL wb_req_drops got %0d want 1", req_falls); end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL wb_done_count got %0d want 1", done_cnt); end
    tests++; if (done_cyc != 50) begin fails++; $display("FAIL wb_latency got %0d want 50", done_cyc); end
    tests++; if (line_read[3*WW +: WW] !== 32'h00000123) begin fails++; $display("FAIL wb_line_kept got %h want 00000123", line_read[3*WW +: WW]); end
  endtask

  task automatic test_write_fill();
    for (int i = 0; i < LW; i++) line_store[i*WW +: WW] = 32'h5A000000 + (i << 4);
    run_op(1'b1, 1'b1, 24'h00ABCD, 1, 1'b0);
    line_store = '0;
    tests++; if (timed_out !== 1'b0) begin fails++; $display("FAIL wf_timeout got %b want 0", timed_out); end
    tests++; if (xfers != 32) begin fails++; $display("FAIL wf_xfers got %0d want 32", xfers); end
    for (int i = 0; i < 16; i++) begin
      tests++; if (xa[i] !== 24'h00ABC0 + 24'(i) || xw[i] !== 1'b1 || xd[i] !== 32'h5A000000 + (i << 4)) begin
        fails++; $display("FAIL wf_write[%0d] got a=%h we=%b d=%h", i, xa[i], xw[i], xd[i]);
      end
      tests++; if (xa[16+i] !== 24'h00ABC0 + 24'(i) || xw[16+i] !== 1'b0) begin
        fails++; $display("FAIL wf_read[%0d] got a=%h we=%b want a=%h we=0", i, xa[16+i], xw[16+i], 24'h00ABC0 + 24'(i));
      end
      tests++; if (line_read[i*WW +: WW] !== 32'h0000ABC0 + i) begin fails++; $display("FAIL wf_line[%0d] got %h want %h", i, line_read[i*WW +: WW], 32'h0000ABC0 + i); end
    end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL wf_done_count got %0d want 1", done_cnt); end
    tests++; if (done_cyc != 34) begin fails++; $display("FAIL wf_latency got %0d want 34", done_cyc); end
    tests++; if (req_falls != 1) begin fails++; $display("FAIL wf_req_drops got %0d want 1", req_falls); end
  endtask

  task automatic test_ignore_busy();
    run_op(1'b1, 1'b0, 24'h000305, 1, 1'b1);
    tests++; if (timed_out !== 1'b0) begin fails++; $display("FAIL ign_timeout got %b want 0", timed_out); end
    tests++; if (xfers != 16 || done_cnt != 1) begin fails++; $display("FAIL ign_counts got xfers=%0d done=%0d want 16/1", xfers, done_cnt); end
    tests++; if (ready_bad != 0) begin fails++; $display("FAIL ign_ready_busy got %0d want 0", ready_bad); end
    repeat (3) @(negedge clk);
    tests++; if (mem_ready !== 1'b1 || ext_req !== 1'b0) begin fails++; $display("FAIL ign_idle_after got ready=%b req=%b want 1/0", mem_ready, ext_req); end
    tests++; if (line_read[9*WW +: WW] !== 32'h00000309) begin fails++; $display("FAIL ign_line got %h want 00000309", line_read[9*WW +: WW]); end
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    mem_r_en = 1'b1; mem_addr = 24'h000040;
    @(negedge clk);
    mem_r_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      ext_ack = 1'b1;
      @(negedge clk);
    end
    ext_ack = 1'b0;
    tests++; if (line_read[4*WW +: WW] !== 32'h00000044 || ext_req !== 1'b1) begin
      fails++; $display("FAIL rmb_pre got word4=%h req=%b want 00000044/1", line_read[4*WW +: WW], ext_req);
    end
    rst = 1'b1;
    #1;
    tests++; if (ext_req !== 1'b0 || mem_ready !== 1'b1 || mem_done !== 1'b0) begin
      fails++; $display("FAIL rmb_reset got req=%b ready=%b done=%b want 0/1/0", ext_req, mem_ready, mem_done);
    end
    tests++; if (line_read !== '0) begin fails++; $display("FAIL rmb_line got nonzero want 0"); end
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b1, 1'b0, 24'h000200, 1, 1'b0);
    tests++; if (timed_out !== 1'b0 || xfers != 16) begin fails++; $display("FAIL rmb_rerun got timeout=%b xfers=%0d want 0/16", timed_out, xfers); end
    tests++; if (xa[0] !== 24'h000200 || line_read[0 +: WW] !== 32'h00000200) begin
      fails++; $display("FAIL rmb_first got a=%h w0=%h want 000200/00000200", xa[0], line_read[0 +: WW]);
    end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL rmb_done_count got %0d want 1", done_cnt); end
  endtask

  initial begin
    rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; mem_addr = '0;
    line_store = '0; ext_ack = 1'b0;
    test_reset();
    test_fill();
    test_spurious_ack();
    test_writeback();
    test_write_fill();
    test_ignore_busy();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
